// File: rtl/fsk_pkg.sv
// Shared widths and FSM state encoding for the FSK receive path.
// Widths are sized so the per-bit integrator cannot overflow for any legal sps.
package fsk_pkg;
  localparam int DW    = 12;
  localparam int SPSW  = 16;
  localparam int PW    = 2 * DW;
  localparam int DISCW = 2 * DW + 1;
  localparam int ACCW  = DW * 2 + 1 + SPSW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    TRACK = 2'd2
  } state_t;
endpackage

// File: rtl/fsk_discriminator.sv
// Phase-rotation discriminator d = I[n-1]*Q[n] - Q[n-1]*I[n]; two-stage pipe.
// Latency 2 clocks from a qualified sample to d_valid; idle cycles pass through as bubbles.
module fsk_discriminator
  import fsk_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DW-1:0]    i_in,
  input  logic signed [DW-1:0]    q_in,
  input  logic                    in_valid,
  output logic signed [DISCW-1:0] d,
  output logic                    d_valid
);
  logic signed [DW-1:0]    prev_i;
  logic signed [DW-1:0]    prev_q;
  logic                    have_prev;
  logic signed [PW-1:0]    p_a;
  logic signed [PW-1:0]    p_b;
  logic                    s1_vld;
  logic signed [DISCW-1:0] diff;

  always_comb begin
    diff = {p_a[PW-1], p_a} - {p_b[PW-1], p_b};
  end

  // The very first sample after reset has no predecessor, so it never reaches stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_i    <= '0;
      prev_q    <= '0;
      have_prev <= 1'b0;
      p_a       <= '0;
      p_b       <= '0;
      s1_vld    <= 1'b0;
      d         <= '0;
      d_valid   <= 1'b0;
    end else begin
      s1_vld  <= in_valid & have_prev;
      d_valid <= s1_vld;
      if (in_valid) begin
        prev_i    <= i_in;
        prev_q    <= q_in;
        have_prev <= 1'b1;
        p_a       <= prev_i * q_in;
        p_b       <= prev_q * i_in;
      end
      if (s1_vld) begin
        d <= diff;
      end
    end
  end
endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for quasi-static configuration words.
// Latency two clocks; no handshake, the source must hold the value steady.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/fsk_demodulator.sv
// Non-coherent FSK bit recovery: discriminator, bit timing and integrate-and-dump per bit.
// Last sample of a bit to bit_valid is 3 clocks; no output backpressure, in_valid gaps only stall.
module fsk_demodulator
  import fsk_pkg::*;
(
  input  logic                 bb_clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] i_in,
  input  logic signed [DW-1:0] q_in,
  input  logic                 in_valid,
  input  logic [SPSW-1:0]      sps,
  input  logic                 invert,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 locked
);
  logic [SPSW-1:0]         sps_s;
  logic [SPSW-1:0]         sps_q;
  logic signed [DISCW-1:0] d;
  logic                    d_valid;

  state_t                  state, state_n;
  logic [SPSW-1:0]         cnt, cnt_n;
  logic signed [ACCW-1:0]  acc, acc_n;
  logic                    corr_done, corr_n;
  logic                    prev_sgn;
  logic                    dump;

  logic                    sps_bad;
  logic                    trans;
  logic signed [ACCW-1:0]  d_ext;
  logic signed [ACCW-1:0]  acc_sum;
  logic [SPSW-1:0]         sps_m1;
  logic [SPSW-1:0]         quarter;
  logic [SPSW+1:0]         sps3;
  logic [SPSW-1:0]         three_q;
  logic                    late;
  logic                    early;
  logic [SPSW-1:0]         slot;

  synchronizer #(.WIDTH(SPSW)) u_sps_sync (
    .clk   (bb_clk),
    .rst_n (rst_n),
    .d     (sps),
    .q     (sps_s)
  );

  fsk_discriminator u_disc (
    .clk      (bb_clk),
    .rst_n    (rst_n),
    .i_in     (i_in),
    .q_in     (q_in),
    .in_valid (in_valid),
    .d        (d),
    .d_valid  (d_valid)
  );

  assign locked = (state == TRACK);

  always_comb begin
    sps_bad = (sps_s != sps_q) || (sps_s < SPSW'(2));
    trans   = d_valid && (d[DISCW-1] != prev_sgn) && (d != '0);
    d_ext   = {{(ACCW-DISCW){d[DISCW-1]}}, d};
    acc_sum = acc + d_ext;
    sps_m1  = sps_s - SPSW'(1);
    quarter = sps_s >> 2;
    sps3    = {2'b00, sps_s} + {1'b0, sps_s, 1'b0};
    three_q = sps3[SPSW+1:2];
    late    = trans && !corr_done && (cnt != '0) && (cnt < quarter);
    early   = trans && !corr_done && (cnt > three_q) && (cnt < sps_m1);
    // cnt is the slot of the incoming sample; an early edge makes this sample fill two slots.
    slot    = early ? cnt + SPSW'(1) : cnt;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    corr_n  = corr_done;
    dump    = 1'b0;
    case (state)
      IDLE: begin
        if (!sps_bad) state_n = HUNT;
      end
      HUNT: begin
        if (trans) begin
          state_n = TRACK;
          acc_n   = d_ext;
          cnt_n   = SPSW'(1);
          corr_n  = 1'b0;
        end
      end
      TRACK: begin
        if (d_valid) begin
          acc_n = acc_sum;
          if (late || early) corr_n = 1'b1;
          if (slot == sps_m1) begin
            dump   = 1'b1;
            acc_n  = '0;
            cnt_n  = '0;
            corr_n = 1'b0;
          end else if (late) begin
            cnt_n = cnt;
          end else begin
            cnt_n = slot + SPSW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A config change abandons the partial bit, but a dump decided this cycle still goes out.
    if (state != IDLE && sps_bad) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      corr_n  = 1'b0;
    end
  end

  always_ff @(posedge bb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      corr_done <= 1'b0;
      prev_sgn  <= 1'b0;
      sps_q     <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      corr_done <= corr_n;
      sps_q     <= sps_s;
      bit_valid <= dump;
      if (d_valid) prev_sgn <= d[DISCW-1];
      if (dump) bit_out <= (~acc_sum[ACCW-1]) ^ invert;
    end
  end
endmodule
